oscillator_bank: RTL

OSCILLATOR_BANK -- requirements
Module: oscillator_bank

---
 rtl/osc_pkg.sv | 23 ++
 rtl/osc_if.sv | 17 +
 rtl/osc_voice_shape.sv | 43 ++++
 rtl/oscillator_bank.sv | 103 ++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// osc_pkg: shared constants, FSM states and helpers for the oscillator bank.
package osc_pkg;
    localparam logic [1:0] CFG_INC = 2'd0;
    localparam logic [1:0] CFG_CTRL = 2'd1;
    localparam logic [1:0] CFG_PWIDTH = 2'd2;
    localparam logic [1:0] CFG_VOL = 2'd3;
    localparam int CTL_SAW = 0;
    localparam int CTL_TRI = 1;
    localparam int CTL_SQUARE = 2;
    localparam int CTL_PULSE = 3;
    localparam int CTL_NOISE = 4;
    localparam int CTL_CLR = 5;
    localparam int LFSR_W = 17;
    localparam int LFSR_TAP_A = 16;
    localparam int LFSR_TAP_B = 13;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 17'd1;
    localparam logic [8:0] VOL_UNITY = 9'd256;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    // Normalising shift so that several summed waveforms stay within one sample range.
    function automatic logic [1:0] submix_shift(input logic [2:0] n);
        return n >= 3'd5 ? 2'd3 : n >= 3'd3 ? 2'd2 : n == 3'd2 ? 2'd1 : 2'd0;
    endfunction
endpackage

// File: rtl/osc_if.sv
// osc_if: frame trigger, configuration write port and mixed sample output.
interface osc_if #(parameter int BITDEPTH = 12, parameter int VOICES = 8);
    localparam int VW = $clog2(VOICES);
    logic sample_tick;
    logic cfg_we;
    logic [VW-1:0] cfg_voice;
    logic [1:0] cfg_addr;
    logic [20:0] cfg_wdata;
    logic busy;
    logic overrun;
    logic [BITDEPTH-1:0] out;
    logic out_valid;
    modport master (output sample_tick, cfg_we, cfg_voice, cfg_addr, cfg_wdata,
                    input busy, overrun, out, out_valid);
    modport slave (input sample_tick, cfg_we, cfg_voice, cfg_addr, cfg_wdata,
                   output busy, overrun, out, out_valid);
endinterface

// File: rtl/osc_voice_shape.sv
// osc_voice_shape: derives saw/triangle/square/pulse/noise from a phase and
// returns the normalised signed submix of the selected waveforms.
module osc_voice_shape
    import osc_pkg::*;
#(
    parameter int BITDEPTH = 12,
    parameter int BITFRACTION = 8,
    localparam int PW = BITDEPTH + BITFRACTION
) (
    input  logic [PW-1:0] phase,
    input  logic [4:0] control,
    input  logic [BITDEPTH-1:0] pwidth,
    input  logic [LFSR_W-1:0] lfsr,
    output logic signed [BITDEPTH-1:0] submix
);
    logic [BITDEPTH-1:0] top;
    logic [BITDEPTH-1:0] wave [5];
    logic [BITDEPTH-1:0] off;
    logic signed [BITDEPTH+2:0] sum;
    logic signed [BITDEPTH+2:0] shifted;
    logic [2:0] n;
    always_comb begin
        top = phase[PW-1 -: BITDEPTH];
        wave[CTL_SAW] = top;
        wave[CTL_TRI] = phase[PW-1] ? ~phase[PW-2 -: BITDEPTH] : phase[PW-2 -: BITDEPTH];
        wave[CTL_SQUARE] = {BITDEPTH{phase[PW-1]}};
        wave[CTL_PULSE] = {BITDEPTH{top < pwidth}};
        wave[CTL_NOISE] = lfsr[LFSR_W-1 -: BITDEPTH];
        sum = '0;
        n = '0;
        off = '0;
        // Flipping the MSB re-centres an unsigned wave around zero.
        for (int i = 0; i < 5; i++) begin
            if (control[i]) begin
                off = {~wave[i][BITDEPTH-1], wave[i][BITDEPTH-2:0]};
                sum = sum + {{3{off[BITDEPTH-1]}}, off};
                n = n + 3'd1;
            end
        end
        shifted = sum >>> submix_shift(n);
        submix = shifted[BITDEPTH-1:0];
    end
endmodule

// File: rtl/oscillator_bank.sv
// oscillator_bank: per-voice registers, frame FSM, volume mixer and
// output saturation around the unsigned midpoint.
module oscillator_bank
    import osc_pkg::*;
#(
    parameter int BITDEPTH = 12,
    parameter int BITFRACTION = 8,
    parameter int VOICES = 8
) (
    input logic sample_clock,
    input logic reset,
    osc_if.slave bus
);
    localparam int PW = BITDEPTH + BITFRACTION;
    localparam int VW = $clog2(VOICES);
    localparam int MW = BITDEPTH + VW + 1;
    localparam logic [BITDEPTH-1:0] MID = {1'b1, {(BITDEPTH-1){1'b0}}};
    localparam logic signed [MW-1:0] SAT_HI = MW'((1 << (BITDEPTH-1)) - 1);
    localparam logic signed [MW-1:0] SAT_LO = MW'(-(1 << (BITDEPTH-1)));

    logic [20:0] increment [VOICES];
    logic [PW-1:0] phase [VOICES];
    logic [4:0] control [VOICES];
    logic [BITDEPTH-1:0] pwidth [VOICES];
    logic [8:0] volume [VOICES];
    state_t state, next_state;
    logic [VW-1:0] idx;
    logic signed [MW-1:0] mix;
    logic [LFSR_W-1:0] lfsr;
    logic [PW-1:0] new_phase;
    logic signed [BITDEPTH-1:0] submix;
    logic signed [BITDEPTH+9:0] scaled;
    logic signed [BITDEPTH+1:0] contrib;
    logic [BITDEPTH-1:0] sat_out;

    osc_voice_shape #(.BITDEPTH(BITDEPTH), .BITFRACTION(BITFRACTION)) shape (
        .phase(new_phase),
        .control(control[idx]),
        .pwidth(pwidth[idx]),
        .lfsr(lfsr),
        .submix(submix)
    );

    always_comb begin
        next_state = state == IDLE ? (bus.sample_tick ? RUN : IDLE)
                   : state == RUN ? (idx == VW'(VOICES - 1) ? DONE : RUN)
                   : IDLE;
        new_phase = phase[idx] + PW'(increment[idx]);
        scaled = submix * $signed({1'b0, volume[idx]});
        contrib = scaled[BITDEPTH+9:8];
        // In range, adding the midpoint is just an MSB flip.
        sat_out = mix > SAT_HI ? '1 : mix < SAT_LO ? '0 : mix[BITDEPTH-1:0] ^ MID;
    end

    assign bus.busy = state != IDLE;

    always_ff @(posedge sample_clock) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            mix <= '0;
            lfsr <= LFSR_SEED;
            bus.out <= MID;
            bus.out_valid <= 1'b0;
            bus.overrun <= 1'b0;
            for (int v = 0; v < VOICES; v++) begin
                increment[v] <= '0;
                phase[v] <= '0;
                control[v] <= '0;
                pwidth[v] <= '0;
                volume[v] <= VOL_UNITY;
            end
        end else begin
            state <= next_state;
            bus.out_valid <= state == DONE;
            if (state != IDLE && bus.sample_tick) bus.overrun <= 1'b1;
            if (state == IDLE) begin
                idx <= '0;
                mix <= '0;
            end
            if (state == RUN) begin
                phase[idx] <= new_phase;
                mix <= mix + MW'(contrib);
                idx <= idx + 1'b1;
            end
            if (state == DONE) begin
                bus.out <= sat_out;
                lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
            end
            // Config writes come last so a phase clear overrides the same-cycle advance.
            if (bus.cfg_we) begin
                if (bus.cfg_addr == CFG_INC) increment[bus.cfg_voice] <= bus.cfg_wdata;
                if (bus.cfg_addr == CFG_CTRL) begin
                    control[bus.cfg_voice] <= bus.cfg_wdata[4:0];
                    if (bus.cfg_wdata[CTL_CLR]) phase[bus.cfg_voice] <= '0;
                end
                if (bus.cfg_addr == CFG_PWIDTH) pwidth[bus.cfg_voice] <= bus.cfg_wdata[BITDEPTH-1:0];
                if (bus.cfg_addr == CFG_VOL)
                    volume[bus.cfg_voice] <= bus.cfg_wdata > 21'(VOL_UNITY) ? VOL_UNITY : bus.cfg_wdata[8:0];
            end
        end
    end
endmodule
